counter_updown_mod: RTL and testbench

Parametrised up/down modulo counter with a programmable window [lo_lim, hi_lim], synchronous load and clear, and a selectable wrap or saturate mode. It provides a combinational terminal-count flag, a registered wrap pulse and a saturating wrap-event counter. It is the general-purpose successor to the fixed up-count/carry-out utility counter. Targets are router timers, arbiter round-robin pointers and flit/packet counters in the NoC.

---
 rtl/counter_updown_mod_if.sv | 30 +++
 rtl/counter_updown_mod.sv | 102 ++++++++++
 tb/tb_counter_updown_mod.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_updown_mod_if.sv
// Control and status bundle for counter_updown_mod. The master drives the
// controls and limits; the slave (the counter) returns the count and flags.
interface counter_updown_mod_if #(
  parameter int WIDTH  = 6,
  parameter int WRAP_W = 4
);
  logic              clr;
  logic              ld;
  logic [WIDTH-1:0]  ld_val;
  logic              cnt_en;
  logic              up_dn;
  logic              sat;
  logic [WIDTH-1:0]  lo_lim;
  logic [WIDTH-1:0]  hi_lim;
  logic [WIDTH-1:0]  cnt;
  logic              tc;
  logic              wrap_p;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              cfg_err;

  modport master (
    output clr, ld, ld_val, cnt_en, up_dn, sat, lo_lim, hi_lim,
    input  cnt, tc, wrap_p, wrap_cnt, cfg_err
  );

  modport slave (
    input  clr, ld, ld_val, cnt_en, up_dn, sat, lo_lim, hi_lim,
    output cnt, tc, wrap_p, wrap_cnt, cfg_err
  );
endinterface

// File: rtl/counter_updown_mod.sv
// Up/down modulo counter over a programmable window [lo_lim, hi_lim] with
// wrap or saturate mode, terminal-count flag, wrap pulse and wrap counter.
module counter_updown_mod #(
  parameter int               WIDTH   = 6,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               WRAP_W  = 4
) (
  input logic                 clk,
  input logic                 rst,
  counter_updown_mod_if.slave bus
);

  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

  logic [WIDTH-1:0]  r_cnt;
  logic              r_wrap_p;
  logic [WRAP_W-1:0] r_wrap_cnt;

  logic              w_cfg_ok;
  logic              w_at_lim;
  logic [WIDTH-1:0]  w_next;
  logic              w_wrap;
  logic              w_tc;

  assign w_cfg_ok = (bus.lo_lim <= bus.hi_lim);

  // Limit detection: at-or-beyond the limit in the current direction, which
  // also covers out-of-window values so +1/-1 never overflows.
  always_comb begin
    w_at_lim = 1'b0;
    if (bus.up_dn) begin
      w_at_lim = (r_cnt >= bus.hi_lim);
    end else begin
      w_at_lim = (r_cnt <= bus.lo_lim);
    end
  end

  // Next count value and wrap decision for one enabled step.
  always_comb begin
    w_next = r_cnt;
    w_wrap = 1'b0;
    case ({w_at_lim, bus.sat, bus.up_dn})
      3'b000, 3'b010: w_next = r_cnt - {{(WIDTH-1){1'b0}}, 1'b1};
      3'b001, 3'b011: w_next = r_cnt + {{(WIDTH-1){1'b0}}, 1'b1};
      3'b100: begin
        w_next = bus.hi_lim;
        w_wrap = 1'b1;
      end
      3'b101: begin
        w_next = bus.lo_lim;
        w_wrap = 1'b1;
      end
      3'b110: w_next = bus.lo_lim;
      3'b111: w_next = bus.hi_lim;
      default: begin
        w_next = r_cnt;
        w_wrap = 1'b0;
      end
    endcase
  end

  // Terminal count is deliberately not gated by ld/clr.
  always_comb begin
    w_tc = 1'b0;
    if (bus.cnt_en && w_cfg_ok) begin
      w_tc = w_at_lim;
    end else begin
      w_tc = 1'b0;
    end
  end

  // Count state, wrap pulse and saturating wrap counter, priority clr > ld > step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= RST_VAL;
      r_wrap_p   <= 1'b0;
      r_wrap_cnt <= {WRAP_W{1'b0}};
    end else if (bus.clr) begin
      r_cnt      <= RST_VAL;
      r_wrap_p   <= 1'b0;
      r_wrap_cnt <= {WRAP_W{1'b0}};
    end else if (bus.ld) begin
      r_cnt    <= bus.ld_val;
      r_wrap_p <= 1'b0;
    end else if (bus.cnt_en && w_cfg_ok) begin
      r_cnt    <= w_next;
      r_wrap_p <= w_wrap;
      if (w_wrap && (r_wrap_cnt != WRAP_MAX)) begin
        r_wrap_cnt <= r_wrap_cnt + {{(WRAP_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_wrap_p <= 1'b0;
    end
  end

  assign bus.cnt      = r_cnt;
  assign bus.wrap_p   = r_wrap_p;
  assign bus.wrap_cnt = r_wrap_cnt;
  assign bus.tc       = w_tc;
  assign bus.cfg_err  = ~w_cfg_ok;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Self-checking bench for counter_updown_mod: directed scenarios followed by
// randomized traffic, all compared against an integer reference model.
module tb_counter_updown_mod;
  localparam int               WIDTH   = 4;
  localparam int               WRAP_W  = 4;
  localparam logic [WIDTH-1:0] RST_VAL = 4'd1;
  localparam int               WMAX    = (1 << WRAP_W) - 1;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  int   m_cnt;
  int   m_wcnt;
  int   m_wp;

  counter_updown_mod_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) bus ();

  counter_updown_mod #(.WIDTH(WIDTH), .RST_VAL(RST_VAL), .WRAP_W(WRAP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_cnt  = int'(RST_VAL);
    m_wcnt = 0;
    m_wp   = 0;
  endfunction

  // Expected terminal count from the current model state and live inputs.
  function automatic int model_tc();
    int lo = int'(bus.lo_lim);
    int hi = int'(bus.hi_lim);
    if (!bus.cnt_en || lo > hi) return 0;
    if (bus.up_dn) return (m_cnt >= hi) ? 1 : 0;
    return (m_cnt <= lo) ? 1 : 0;
  endfunction

  // Advance the model by one clock edge using the inputs presented now.
  function automatic void model_edge();
    int lo = int'(bus.lo_lim);
    int hi = int'(bus.hi_lim);
    m_wp = 0;
    if (bus.clr) begin
      m_cnt  = int'(RST_VAL);
      m_wcnt = 0;
    end else if (bus.ld) begin
      m_cnt = int'(bus.ld_val);
    end else if (bus.cnt_en && lo <= hi) begin
      if (bus.up_dn) begin
        if (m_cnt < hi) m_cnt = m_cnt + 1;
        else if (bus.sat) m_cnt = hi;
        else begin m_cnt = lo; m_wp = 1; end
      end else begin
        if (m_cnt > lo) m_cnt = m_cnt - 1;
        else if (bus.sat) m_cnt = lo;
        else begin m_cnt = hi; m_wp = 1; end
      end
      if (m_wp == 1 && m_wcnt < WMAX) m_wcnt = m_wcnt + 1;
    end
  endfunction

  // One clock: check combinational flags, clock the DUT, check registered state.
  task automatic cycle();
    #1;
    check("tc", int'(bus.tc), model_tc());
    check("cfg_err", int'(bus.cfg_err), (bus.lo_lim > bus.hi_lim) ? 1 : 0);
    model_edge();
    @(posedge clk);
    #1;
    check("cnt", int'(bus.cnt), m_cnt);
    check("wrap_p", int'(bus.wrap_p), m_wp);
    check("wrap_cnt", int'(bus.wrap_cnt), m_wcnt);
  endtask

  task automatic set_ctl(input logic clr_v, input logic ld_v, input int ldv,
                         input logic en_v, input logic up_v, input logic sat_v);
    bus.clr    = clr_v;
    bus.ld     = ld_v;
    bus.ld_val = ldv[WIDTH-1:0];
    bus.cnt_en = en_v;
    bus.up_dn  = up_v;
    bus.sat    = sat_v;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    set_ctl(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    bus.lo_lim = 4'd3;
    bus.hi_lim = 4'd6;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt", int'(bus.cnt), int'(RST_VAL));
    check("rst_wrap_p", int'(bus.wrap_p), 0);
    check("rst_wrap_cnt", int'(bus.wrap_cnt), 0);
    rst = 1'b0;

    // Wrap-mode up count through the window twice.
    set_ctl(1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b0);
    cycle();
    set_ctl(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    repeat (8) cycle();
    check("p1_cnt", int'(bus.cnt), 3);
    check("p1_wrap_cnt", int'(bus.wrap_cnt), 2);

    // Saturating down count stops at lo_lim.
    set_ctl(1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b1);
    cycle();
    set_ctl(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    repeat (4) cycle();
    check("p2_cnt", int'(bus.cnt), 3);
    check("p2_wrap_cnt", int'(bus.wrap_cnt), 2);

    // Out-of-window start value, wrap then saturate.
    set_ctl(1'b0, 1'b1, 12, 1'b0, 1'b1, 1'b0);
    cycle();
    set_ctl(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    cycle();
    check("p3_wrap_cnt", int'(bus.cnt), 3);
    check("p3_wrap_p", int'(bus.wrap_p), 1);
    set_ctl(1'b0, 1'b1, 12, 1'b0, 1'b1, 1'b1);
    cycle();
    set_ctl(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b1);
    cycle();
    check("p3_sat_cnt", int'(bus.cnt), 6);
    check("p3_sat_wrap_p", int'(bus.wrap_p), 0);

    // Asynchronous reset between edges.
    set_ctl(1'b0, 1'b1, 5, 1'b0, 1'b1, 1'b0);
    cycle();
    set_ctl(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_cnt", int'(bus.cnt), int'(RST_VAL));
    check("arst_wrap_p", int'(bus.wrap_p), 0);
    check("arst_wrap_cnt", int'(bus.wrap_cnt), 0);
    model_reset();
    #1;
    rst = 1'b0;
    repeat (3) cycle();
    check("arst_resume", int'(bus.cnt), int'(RST_VAL) + 3);

    // Priority: clr beats ld beats count.
    set_ctl(1'b0, 1'b1, 5, 1'b0, 1'b1, 1'b0);
    cycle();
    set_ctl(1'b1, 1'b1, 5, 1'b1, 1'b1, 1'b0);
    cycle();
    check("p4_clr", int'(bus.cnt), int'(RST_VAL));
    set_ctl(1'b0, 1'b1, 9, 1'b1, 1'b1, 1'b0);
    cycle();
    check("p4_ld", int'(bus.cnt), 9);

    // Bad window holds the counter, then single-value window wraps every cycle.
    bus.lo_lim = 4'd8;
    bus.hi_lim = 4'd2;
    set_ctl(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    repeat (5) cycle();
    check("p5_hold", int'(bus.cnt), 9);
    bus.lo_lim = 4'd7;
    bus.hi_lim = 4'd7;
    repeat (20) cycle();
    check("p5_wrap_sat", int'(bus.wrap_cnt), 15);
    check("p5_wrap_p", int'(bus.wrap_p), 1);

    // Randomized traffic with occasional clears, loads and limit changes.
    for (int i = 0; i < 600; i++) begin
      set_ctl(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
              int'($urandom_range(0, 15)),
              ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      if ($urandom_range(0, 15) == 0) begin
        bus.lo_lim = 4'($urandom_range(0, 15));
        bus.hi_lim = 4'($urandom_range(0, 15));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
